dac_stream_scheduler: RTL
=========================

# dac_stream_scheduler

Sequences the host-to-DAC sample stream for `multi_dac_interface`. It sits between the host FIFO (first-word-fall-through, `bus_clk` side already synchronized to `capture_clk`) and the DAC serializer. It answers each `dac_rden` request with a 32-bit word taken from the FIFO, from an internal test pattern, or as mute (zero). It also primes the stream on open and accounts for underruns.

## Interface
- `WORD_W`, 32, DAC word width.
- `PRIME_CYCLES`, 16, consecutive non-empty FIFO cycles required before streaming starts (range 1..255).
- `UNDERRUN_W`, 16, width of the underrun counter.

- `capture_clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `dac_open_bus`  in  1  host stream open; level.
- `fifo_data`  in  WORD_W  FIFO head word, valid when `!fifo_empty`.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rden`  out  1  combinational pop strobe to the FIFO.
- `dac_rden`  in  1  word request from `multi_dac_interface`; one request per cycle high.
- `dac_data`  out  WORD_W  registered word presented to the serializer.
- `test_enable`  in  1  selects the test pattern source.
- `clear_status`  in  1  synchronous clear of `underrun` and `underrun_count`.
- `dac_running`  out  1  high in RUN state.
- `underrun`  out  1  sticky underrun flag.
- `underrun_count`  out  UNDERRUN_W  saturating underrun event count.

## Operation
- States:
  - IDLE: mute.
  - PRIME: mute, waiting for the FIFO to fill.
  - RUN: streaming.
- Transitions, evaluated every edge:
  - IDLE -> PRIME when `dac_open_bus`=1.
  - PRIME -> RUN when the prime counter reaches `PRIME_CYCLES`.
  - PRIME or RUN -> IDLE when `dac_open_bus`=0. This has priority over every other transition.
  - RUN stays in RUN on underrun; there is no automatic re-prime.
- Prime counter:
  - Cleared outside PRIME.
  - In PRIME it increments on cycles with `!fifo_empty` and clears on any cycle with `fifo_empty`.
- Word selection on a cycle with `dac_rden`=1, priority top-down:
  - `test_enable`=1: load the pattern word {n,4'hA,n,4'hB,n,4'hC,n,4'hD}, where n is a 4-bit counter. n then increments and wraps 15->0. FIFO is untouched and no underrun is counted. n holds when not requested.
  - state != RUN: load 0. No pop, no underrun.
  - RUN and `!fifo_empty`: `fifo_rden`=1 this cycle, and `dac_data` loads `fifo_data`.
  - RUN and `fifo_empty`: load 0, set `underrun`, and increment `underrun_count` (saturates at all-ones).
- `fifo_rden` = `dac_rden` & `!test_enable` & (state==RUN) & `!fifo_empty`. It is never asserted otherwise.
- `dac_data` holds its value on cycles without `dac_rden`. The exception is the edge entering IDLE from PRIME or RUN, where it loads 0.
- `clear_status`: `underrun` clears to 0 and the count to 0. If an underrun event occurs in the same cycle, the event wins: `underrun`=1, count=1.

## Timing
- Reset values:
  - state IDLE
  - `dac_data`=0
  - `dac_running`=0
  - `underrun`=0
  - `underrun_count`=0
  - n=1
  - prime counter 0
  - `fifo_rden`=0 (combinational; state is IDLE)
- Latency: `dac_rden` sampled high at edge k -> new `dac_data` visible after edge k. Back-to-back `dac_rden` cycles are each honored and each pops one FIFO word.
- `fifo_rden` is asserted in the same cycle as `dac_rden`. The FIFO advances at the same edge that captures `fifo_data`.
- The first RUN cycle is PRIME_CYCLES+1 edges after `dac_open_bus` rises, given a continuously non-empty FIFO. `dac_running` is registered and coincident with state RUN.
- If `dac_open_bus` falls in the same cycle as `dac_rden` while in RUN:
  - the request is served per RUN rules (pop if data present);
  - the state becomes IDLE;
  - `dac_data` loads the selected word at that edge, not 0. The zeroing applies only when no request is present.
- Mid-operation `reset` immediately forces all reset values, without waiting for a clock edge.

## Test plan
- Reset, then open with FIFO holding 0x11111111, 0x22222222, and `dac_rden` pulsed every 8 cycles -> zeros until `dac_running`. Then `dac_data` = 0x11111111, then 0x22222222, with `fifo_rden` high exactly on those two request cycles.
- PRIME with `fifo_empty` toggling low 10 cycles / high 1 cycle / low 16 cycles (`PRIME_CYCLES`=16) -> RUN entered only after the second run of 16, at the 17th edge.
- RUN, FIFO drained, 3 requests -> `dac_data`=0 each time, `underrun`=1, `underrun_count`=3. Then `clear_status` alone -> 0/0. `clear_status` coincident with an underrun -> `underrun`=1, count=1.
- `test_enable`=1 with 17 requests from reset -> words 0x1A1B1C1D, 0x2A2B2C2D, ... 0xFAFBFCFD, 0x0A0B0C0D, 0x1A1B1C1D. `fifo_rden` stays 0.
- Set `underrun_count` near saturation with `UNDERRUN_W`=4 and apply 20 underruns -> count holds 15.
- Drop `dac_open_bus` in RUN without a request -> IDLE next edge, `dac_data`=0, `dac_running`=0. Assert `reset` mid-stream asynchronously -> all outputs at reset values before the next edge.

Source files
------------

// File: rtl/dac_stream_scheduler.sv
// Sequences the host-to-DAC sample stream: primes on open, then answers each
// dac_rden with a FIFO word, a test pattern or mute, and tracks underruns.
module dac_stream_scheduler #(
  parameter int WORD_W       = 32,
  parameter int PRIME_CYCLES = 16,
  parameter int UNDERRUN_W   = 16
) (
  input  logic                  capture_clk,
  input  logic                  reset,
  input  logic                  dac_open_bus,
  input  logic [WORD_W-1:0]     fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rden,
  input  logic                  dac_rden,
  output logic [WORD_W-1:0]     dac_data,
  input  logic                  test_enable,
  input  logic                  clear_status,
  output logic                  dac_running,
  output logic                  underrun,
  output logic [UNDERRUN_W-1:0] underrun_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            prime_cnt_q, prime_cnt_d;
  logic [3:0]            pattern_n_q, pattern_n_d;
  logic [WORD_W-1:0]     dac_data_q, dac_data_d;
  logic                  running_q, running_d;
  logic                  underrun_q, underrun_d;
  logic [UNDERRUN_W-1:0] underrun_count_q, underrun_count_d;

  logic        pop;
  logic        underrun_event;
  logic        closing;
  logic [31:0] pattern_word;

  assign pattern_word = {pattern_n_q, 4'hA, pattern_n_q, 4'hB,
                         pattern_n_q, 4'hC, pattern_n_q, 4'hD};
  assign closing      = (state_q != IDLE) && !dac_open_bus;

  always_comb begin
    state_d          = state_q;
    prime_cnt_d      = 8'd0;
    pattern_n_d      = pattern_n_q;
    dac_data_d       = dac_data_q;
    underrun_d       = underrun_q;
    underrun_count_d = underrun_count_q;
    pop              = 1'b0;
    underrun_event   = 1'b0;

    // A pending request is always served, even on the edge that closes the stream.
    if (dac_rden) begin
      if (test_enable) begin
        dac_data_d  = WORD_W'(pattern_word);
        pattern_n_d = pattern_n_q + 4'd1;
      end else if (state_q != RUN) begin
        dac_data_d = '0;
      end else if (!fifo_empty) begin
        dac_data_d = fifo_data;
        pop        = 1'b1;
      end else begin
        dac_data_d     = '0;
        underrun_event = 1'b1;
      end
    end else if (closing) begin
      dac_data_d = '0;
    end

    if (underrun_event) begin
      underrun_d = 1'b1;
      if (clear_status) begin
        underrun_count_d = UNDERRUN_W'(1);
      end else if (underrun_count_q != '1) begin
        underrun_count_d = underrun_count_q + UNDERRUN_W'(1);
      end
    end else if (clear_status) begin
      underrun_d       = 1'b0;
      underrun_count_d = '0;
    end

    if (state_q == PRIME && !fifo_empty) begin
      prime_cnt_d = prime_cnt_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (dac_open_bus) begin
          state_d = PRIME;
        end
      end
      PRIME: begin
        if (!dac_open_bus) begin
          state_d = IDLE;
        end else if (prime_cnt_d == 8'(PRIME_CYCLES)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!dac_open_bus) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != PRIME) begin
      prime_cnt_d = 8'd0;
    end

    running_d = (state_d == RUN);
  end

  always_ff @(posedge capture_clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      prime_cnt_q      <= 8'd0;
      pattern_n_q      <= 4'd1;
      dac_data_q       <= '0;
      running_q        <= 1'b0;
      underrun_q       <= 1'b0;
      underrun_count_q <= '0;
    end else begin
      state_q          <= state_d;
      prime_cnt_q      <= prime_cnt_d;
      pattern_n_q      <= pattern_n_d;
      dac_data_q       <= dac_data_d;
      running_q        <= running_d;
      underrun_q       <= underrun_d;
      underrun_count_q <= underrun_count_d;
    end
  end

  assign fifo_rden      = pop;
  assign dac_data       = dac_data_q;
  assign dac_running    = running_q;
  assign underrun       = underrun_q;
  assign underrun_count = underrun_count_q;

endmodule
